// File: rtl/reaction_ctrl_if.sv
// Reaction timer bus: player/clock-divider inputs and display/status outputs.
//   tick, start, stop : tick pulse, start button level, stop button level
//   tens, ones        : BCD display digits (F = blank, E = foul mark)
//   state             : IDLE=0, WAIT=1, PLAY=2, DONE=3
//   go, foul, timeout : react-now indicator, early-press flag, saturation flag
interface reaction_ctrl_if;
    logic       tick;
    logic       start;
    logic       stop;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] state;
    logic       go;
    logic       foul;
    logic       timeout;

    modport master (
        output tick, start, stop,
        input  tens, ones, state, go, foul, timeout
    );

    modport slave (
        input  tick, start, stop,
        output tens, ones, state, go, foul, timeout
    );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction timer controller: random arming delay, BCD reaction count in
// 0.1 s ticks, foul/timeout detection and best-time memory.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : reaction_ctrl_if slave (inputs tick/start/stop, registered outputs)
module reaction_ctrl #(
    parameter int unsigned DELAY_MIN = 10,
    parameter int unsigned RAND_BITS = 5,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic            clk,
    input logic            reset,
    reaction_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] BLANK     = 4'hF;
    localparam logic [3:0] FOUL_MARK = 4'hE;
    localparam logic [7:0] RAND_MASK = 8'((9'd1 << RAND_BITS) - 9'd1);

    state_t     state_q, state_n;
    logic [3:0] tens_q, tens_n, ones_q, ones_n;
    logic [3:0] cnt_t_q, cnt_t_n, cnt_o_q, cnt_o_n;
    logic [7:0] delay_q, delay_n;
    logic [7:0] best_q, best_n;
    logic       best_valid_q, best_valid_n;
    logic       go_q, go_n, foul_q, foul_n, timeout_q, timeout_n;
    logic [7:0] lfsr_q, lfsr_n;
    logic       start_q, start_prev, stop_q, stop_prev, tick_q;
    logic       start_press, stop_press;

    // Inputs are registered once, so an event acts one edge after it is sampled.
    assign start_press = start_q & ~start_prev;
    assign stop_press  = stop_q  & ~stop_prev;

    // x^8+x^6+x^5+x^4+1, free-running
    assign lfsr_n = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tens_q       <= BLANK;
            ones_q       <= BLANK;
            cnt_t_q      <= 4'd0;
            cnt_o_q      <= 4'd0;
            delay_q      <= 8'd0;
            best_q       <= 8'd0;
            best_valid_q <= 1'b0;
            go_q         <= 1'b0;
            foul_q       <= 1'b0;
            timeout_q    <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            start_q      <= 1'b1;
            start_prev   <= 1'b1;
            stop_q       <= 1'b1;
            stop_prev    <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            tens_q       <= tens_n;
            ones_q       <= ones_n;
            cnt_t_q      <= cnt_t_n;
            cnt_o_q      <= cnt_o_n;
            delay_q      <= delay_n;
            best_q       <= best_n;
            best_valid_q <= best_valid_n;
            go_q         <= go_n;
            foul_q       <= foul_n;
            timeout_q    <= timeout_n;
            lfsr_q       <= lfsr_n;
            start_q      <= bus.start;
            start_prev   <= start_q;
            stop_q       <= bus.stop;
            stop_prev    <= stop_q;
            tick_q       <= bus.tick;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state_q;
        tens_n       = tens_q;
        ones_n       = ones_q;
        cnt_t_n      = cnt_t_q;
        cnt_o_n      = cnt_o_q;
        delay_n      = delay_q;
        best_n       = best_q;
        best_valid_n = best_valid_q;
        foul_n       = foul_q;
        timeout_n    = timeout_q;

        case (state_q)
            IDLE: begin
                tens_n = best_valid_q ? best_q[7:4] : BLANK;
                ones_n = best_valid_q ? best_q[3:0] : BLANK;
                if (start_press) begin
                    state_n = WAIT;
                    delay_n = 8'(DELAY_MIN) + (lfsr_q & RAND_MASK);
                    tens_n  = BLANK;
                    ones_n  = BLANK;
                end
            end
            WAIT: begin
                // Early press beats a coincident tick
                if (stop_press) begin
                    state_n = DONE;
                    foul_n  = 1'b1;
                    tens_n  = FOUL_MARK;
                    ones_n  = FOUL_MARK;
                end else if (tick_q) begin
                    if (delay_q == 8'd1) begin
                        state_n = PLAY;
                        cnt_t_n = 4'd0;
                        cnt_o_n = 4'd0;
                        tens_n  = 4'd0;
                        ones_n  = 4'd0;
                    end else begin
                        delay_n = delay_q - 8'd1;
                    end
                end
            end
            PLAY: begin
                if (stop_press) begin
                    // BCD digits compare correctly as one 8-bit number
                    state_n = DONE;
                    if (!best_valid_q || ({cnt_t_q, cnt_o_q} < best_q)) begin
                        best_n = {cnt_t_q, cnt_o_q};
                    end
                    best_valid_n = 1'b1;
                end else if (tick_q) begin
                    if (cnt_t_q == 4'd9 && cnt_o_q == 4'd9) begin
                        state_n   = DONE;
                        timeout_n = 1'b1;
                    end else begin
                        if (cnt_o_q == 4'd9) begin
                            cnt_o_n = 4'd0;
                            cnt_t_n = 4'(cnt_t_q + 4'd1);
                        end else begin
                            cnt_o_n = 4'(cnt_o_q + 4'd1);
                        end
                        tens_n = cnt_t_n;
                        ones_n = cnt_o_n;
                    end
                end
            end
            DONE: begin
                if (start_press) begin
                    state_n   = IDLE;
                    foul_n    = 1'b0;
                    timeout_n = 1'b0;
                    tens_n    = best_valid_q ? best_q[7:4] : BLANK;
                    ones_n    = best_valid_q ? best_q[3:0] : BLANK;
                end
            end
            default: state_n = IDLE;
        endcase

        go_n = (state_n == PLAY);
    end

    assign bus.tens    = tens_q;
    assign bus.ones    = ones_q;
    assign bus.state   = state_q;
    assign bus.go      = go_q;
    assign bus.foul    = foul_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a fixed 3-tick arming delay.
// Expected display/status words are queued before each stimulus step and
// popped once the one-cycle output latency has elapsed.
module tb_reaction_ctrl;
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [1:0] state;
        logic       go;
        logic       foul;
        logic       timeout;
    } out_t;

    logic clk;
    logic reset;
    reaction_ctrl_if bus ();

    reaction_ctrl #(
        .DELAY_MIN(3),
        .RAND_BITS(0),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    out_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [3:0] t, input logic [3:0] o,
                            input logic [1:0] s, input logic g, input logic f, input logic to);
        out_t e;
        e = '{tens: t, ones: o, state: s, go: g, foul: f, timeout: to};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        out_t  e;
        out_t  obs;
        string tag;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        obs = {bus.tens, bus.ones, bus.state, bus.go, bus.foul, bus.timeout};
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h (tens ones state go foul timeout)", tag, obs, e);
        end
    endtask

    // Each pulse task starts and ends just after a falling edge; on return
    // the event's effect is already on the outputs.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_stop_tick();
        bus.stop = 1'b1;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        bus.tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
            @(negedge clk);
        end
    endtask

    // One full round ending in a valid stop at count c (BCD digits t,o)
    task automatic play_round(input string tag, input logic [3:0] t, input logic [3:0] o,
                              input int c);
        pulse_start();
        run_ticks(3);
        run_ticks(c);
        push_exp({tag, "_stop"}, t, o, 2'd3, 1'b0, 1'b0, 1'b0);
        pulse_stop();
        check_out();
    endtask

    initial begin
        reset     = 1'b1;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        repeat (3) @(negedge clk);
        push_exp("reset", 4'hF, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // First round: fixed delay of 3 ticks, stop at 27
        push_exp("stop_in_idle", 4'hF, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0);
        pulse_stop();
        check_out();
        push_exp("arm", 4'hF, 4'hF, 2'd1, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_out();
        push_exp("start_in_wait", 4'hF, 4'hF, 2'd1, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_out();
        push_exp("wait_2ticks", 4'hF, 4'hF, 2'd1, 1'b0, 1'b0, 1'b0);
        run_ticks(2);
        check_out();
        push_exp("enter_play", 4'h0, 4'h0, 2'd2, 1'b1, 1'b0, 1'b0);
        run_ticks(1);
        check_out();
        push_exp("count_09", 4'h0, 4'h9, 2'd2, 1'b1, 1'b0, 1'b0);
        run_ticks(9);
        check_out();
        push_exp("count_10_carry", 4'h1, 4'h0, 2'd2, 1'b1, 1'b0, 1'b0);
        run_ticks(1);
        check_out();
        push_exp("start_in_play", 4'h1, 4'h0, 2'd2, 1'b1, 1'b0, 1'b0);
        pulse_start();
        check_out();
        run_ticks(17);
        push_exp("stop_27", 4'h2, 4'h7, 2'd3, 1'b0, 1'b0, 1'b0);
        pulse_stop();
        check_out();
        push_exp("done_holds", 4'h2, 4'h7, 2'd3, 1'b0, 1'b0, 1'b0);
        run_ticks(2);
        pulse_stop();
        check_out();
        push_exp("idle_best_27", 4'h2, 4'h7, 2'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_out();

        // Better round, then worse and equal rounds
        play_round("r15", 4'h1, 4'h5, 15);
        push_exp("idle_best_15", 4'h1, 4'h5, 2'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_out();
        play_round("r40", 4'h4, 4'h0, 40);
        push_exp("idle_best_kept", 4'h1, 4'h5, 2'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_out();

        // Foul after one tick in WAIT
        pulse_start();
        push_exp("foul_wait", 4'hF, 4'hF, 2'd1, 1'b0, 1'b0, 1'b0);
        run_ticks(1);
        check_out();
        push_exp("foul", 4'hE, 4'hE, 2'd3, 1'b0, 1'b1, 1'b0);
        pulse_stop();
        check_out();
        push_exp("foul_clear", 4'h1, 4'h5, 2'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_out();

        // Stop beats a coincident tick that would have ended WAIT
        pulse_start();
        run_ticks(2);
        push_exp("foul_vs_tick", 4'hE, 4'hE, 2'd3, 1'b0, 1'b1, 1'b0);
        pulse_stop_tick();
        check_out();
        pulse_start();

        // Saturation at 99
        pulse_start();
        run_ticks(3);
        push_exp("count_99", 4'h9, 4'h9, 2'd2, 1'b1, 1'b0, 1'b0);
        run_ticks(99);
        check_out();
        push_exp("timeout", 4'h9, 4'h9, 2'd3, 1'b0, 1'b0, 1'b1);
        run_ticks(1);
        check_out();
        push_exp("timeout_hold", 4'h9, 4'h9, 2'd3, 1'b0, 1'b0, 1'b1);
        run_ticks(3);
        check_out();
        push_exp("timeout_clear", 4'h1, 4'h5, 2'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_out();

        // Stop coinciding with a tick at 08 freezes 08
        pulse_start();
        run_ticks(3);
        push_exp("count_08", 4'h0, 4'h8, 2'd2, 1'b1, 1'b0, 1'b0);
        run_ticks(8);
        check_out();
        push_exp("stop_tick_08", 4'h0, 4'h8, 2'd3, 1'b0, 1'b0, 1'b0);
        pulse_stop_tick();
        check_out();
        push_exp("idle_best_08", 4'h0, 4'h8, 2'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_out();

        // Stop held high through reset produces no press
        bus.stop = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_exp("reset_clears_best", 4'hF, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_out();
        pulse_start();
        run_ticks(3);
        push_exp("held_stop_no_press", 4'h0, 4'h1, 2'd2, 1'b1, 1'b0, 1'b0);
        run_ticks(1);
        check_out();
        bus.stop = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-PLAY at count 45
        push_exp("count_45", 4'h4, 4'h5, 2'd2, 1'b1, 1'b0, 1'b0);
        run_ticks(44);
        check_out();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        push_exp("reset_in_play", 4'hF, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        push_exp("no_best_after_reset", 4'hF, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
